// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - sequences one KxK convolution window through the multiplier lanes and final add
module conv_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int KERNEL_SIZE    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                          Clk,
  input  logic                                          Rst_n,
  input  logic                                          start,
  output logic                                          busy,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel_in,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]             multiplier_out,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]             multiplicand_out,
  output logic [KERNEL_SIZE-1:0]                        mStart,
  input  logic [KERNEL_SIZE-1:0]                        mReady,
  output logic                                          finalAdd,
  input  logic [2*DATA_WIDTH-1:0]                       finalAccumulate,
  input  logic                                          finalReady,
  output logic [2*DATA_WIDTH-1:0]                       result,
  output logic                                          result_valid,
  input  logic                                          result_ready,
  output logic                                          timeout_err
);

  localparam int K   = KERNEL_SIZE;
  localparam int DW  = DATA_WIDTH;
  localparam int OPW = K * K * DW;
  localparam int RW  = (K > 1) ? $clog2(K) : 1;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(K - 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_M,
    S_FINAL,
    S_WAIT_F,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [OPW-1:0]      win_q, win_d;
  logic [OPW-1:0]      ker_q, ker_d;
  logic [K-1:0]        mask_q, mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DW-1:0]     result_q, result_d;
  logic                terr_q, terr_d;
  logic                all_ready;
  logic                timed_out;

  // State and datapath registers; reset clears every latched copy
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      win_q    <= '0;
      ker_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      win_q    <= win_d;
      ker_q    <= ker_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      terr_q   <= terr_d;
    end
  end

  // Next-state logic; a lane completing in the same cycle as the limit wins over the abort
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    win_d     = win_q;
    ker_d     = ker_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    terr_d    = terr_q;
    all_ready = &(mask_q | mReady);
    timed_out = (cnt_q == CNT_LIMIT);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d   = window_in;
          ker_d   = kernel_in;
          terr_d  = 1'b0;
          row_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = S_WAIT_M;
      end
      S_WAIT_M: begin
        mask_d = mask_q | mReady;
        if (all_ready) begin
          if (row_q != LAST_ROW) begin
            row_d   = row_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINAL;
          end
        end else if (timed_out) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINAL: begin
        cnt_d   = '0;
        state_d = S_WAIT_F;
      end
      S_WAIT_F: begin
        if (finalReady) begin
          result_d = finalAccumulate;
          state_d  = S_DONE;
        end else if (timed_out) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and status decode straight from the state register
  always_comb begin
    busy         = (state_q != S_IDLE);
    mStart       = {K{state_q == S_ISSUE}};
    finalAdd     = (state_q == S_FINAL);
    result_valid = (state_q == S_DONE);
    result       = result_q;
    timeout_err  = terr_q;
  end

  // Lane operands follow the current row of the latched copies; zero while idle
  always_comb begin
    multiplier_out   = '0;
    multiplicand_out = '0;
    if (state_q != S_IDLE) begin
      for (int r = 0; r < K; r++) begin
        if (row_q == RW'(r)) begin
          for (int j = 0; j < K; j++) begin
            multiplier_out[j*DW +: DW]   = win_q[(r*K + j)*DW +: DW];
            multiplicand_out[j*DW +: DW] = ker_q[(r*K + j)*DW +: DW];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized job schedule bench for conv_sequencer
module tb_conv_sequencer;

  localparam int K   = 3;
  localparam int DW  = 32;
  localparam int T   = 8;
  localparam int N   = 1500;
  localparam int NJ  = 12;
  localparam int OPW = K * K * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic [OPW-1:0]    window_in;
  logic [OPW-1:0]    kernel_in;
  logic [K*DW-1:0]   multiplier_out;
  logic [K*DW-1:0]   multiplicand_out;
  logic [K-1:0]      mStart;
  logic [K-1:0]      mReady;
  logic              finalAdd;
  logic [2*DW-1:0]   finalAccumulate;
  logic              finalReady;
  logic [2*DW-1:0]   result;
  logic              result_valid;
  logic              result_ready;
  logic              timeout_err;

  always #5 clk = ~clk;

  conv_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .TIMEOUT_CYCLES(T)) dut (
    .Clk(clk), .Rst_n(rst_n), .start(start), .busy(busy),
    .window_in(window_in), .kernel_in(kernel_in),
    .multiplier_out(multiplier_out), .multiplicand_out(multiplicand_out),
    .mStart(mStart), .mReady(mReady), .finalAdd(finalAdd),
    .finalAccumulate(finalAccumulate), .finalReady(finalReady),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .timeout_err(timeout_err)
  );

  // per-cycle stimulus schedule
  int          s_start [N];
  bit [K-1:0]  s_mready[N];
  bit          s_fready[N];
  bit          s_rready[N];
  bit          s_rst   [N];
  logic [63:0] s_facc  [N];
  // per-cycle expectations
  bit          e_busy[N], e_mst[N], e_fadd[N], e_rv[N], e_terr[N], e_rchk[N];
  logic [63:0] e_res[N];
  int          e_row[N], e_job[N];

  logic [DW-1:0] win[NJ][K*K];
  logic [DW-1:0] ker[NJ][K*K];
  int dly[K][K];
  int dfin;
  int cyc = 0, n_run = 0, passed = 0, total = 0, j0 = 0;
  logic [K*DW-1:0] em, ek;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic set_dly(input int lo, input int hi);
    for (int r = 0; r < K; r++)
      for (int l = 0; l < K; l++) dly[r][l] = $urandom_range(hi, lo);
  endtask

  task automatic rand_ops(input int j);
    for (int i = 0; i < K*K; i++) begin
      win[j][i] = $urandom;
      ker[j][i] = $urandom;
    end
  endtask

  task automatic mark_timeout(input int t);
    for (int k = t; k < N; k++) e_terr[k] = 1'b1;
    e_row[t] = -2;
  endtask

  // Expected timeline of one job from its start cycle, lane delays and final delay
  task automatic plan_job(input int j, input int c0, input int rr,
                          output int fin_c, output int done_c, output int end_c);
    int c, maxd, d, lim;
    logic [63:0] sum;
    fin_c = -1; done_c = -1;
    s_start[c0] = j + 1;
    for (int k = c0 + 1; k < N; k++) e_terr[k] = 1'b0;
    c = c0 + 1;
    for (int r = 0; r < K; r++) begin
      e_mst[c] = 1'b1; e_busy[c] = 1'b1; e_row[c] = r; e_job[c] = j;
      s_mready[c] = K'($urandom);
      maxd = 0;
      for (int l = 0; l < K; l++) begin
        d = (dly[r][l] == 0) ? T + 1 : dly[r][l];
        if (d > maxd) maxd = d;
        if (d <= T) s_mready[c+d][l] = 1'b1;
      end
      lim = (maxd > T) ? T : maxd;
      for (int k = 1; k <= lim; k++) begin
        e_busy[c+k] = 1'b1; e_row[c+k] = r; e_job[c+k] = j;
      end
      if (maxd > T) begin
        mark_timeout(c + T + 1);
        end_c = c + T + 1;
        return;
      end
      c = c + maxd + 1;
    end
    fin_c = c;
    e_fadd[c] = 1'b1; e_busy[c] = 1'b1;
    d = (dfin == 0) ? T + 1 : dfin;
    lim = (d > T) ? T : d;
    for (int k = 1; k <= lim; k++) e_busy[c+k] = 1'b1;
    if (d > T) begin
      mark_timeout(c + T + 1);
      end_c = c + T + 1;
      return;
    end
    sum = '0;
    for (int i = 0; i < K*K; i++) sum += 64'(win[j][i]) * 64'(ker[j][i]);
    s_fready[c+d] = 1'b1;
    s_facc[c+d]   = sum;
    done_c = c + d + 1;
    for (int k = done_c; k <= done_c + rr; k++) begin
      e_busy[k] = 1'b1; e_rv[k] = 1'b1; e_rchk[k] = 1'b1; e_res[k] = sum;
    end
    s_rready[done_c + rr] = 1'b1;
    end_c = done_c + rr + 1;
  endtask

  task automatic apply_reset(input int from, input int len, input int upto);
    for (int k = from; k < from + len; k++) s_rst[k] = 1'b1;
    for (int k = from; k < upto; k++) begin
      e_busy[k] = 0; e_mst[k] = 0; e_fadd[k] = 0; e_rv[k] = 0; e_rchk[k] = 0; e_row[k] = -1;
    end
    for (int k = from; k < N; k++) e_terr[k] = 1'b0;
    e_row[from] = -2; e_rchk[from] = 1'b1; e_res[from] = '0;
  endtask

  // compare DUT against the planned timeline every cycle
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < n_run) begin
      chk("busy", 128'(busy), 128'(e_busy[cyc]));
      chk("mStart", 128'(mStart), 128'({K{e_mst[cyc]}}));
      chk("finalAdd", 128'(finalAdd), 128'(e_fadd[cyc]));
      chk("result_valid", 128'(result_valid), 128'(e_rv[cyc]));
      chk("timeout_err", 128'(timeout_err), 128'(e_terr[cyc]));
      if (e_rchk[cyc]) chk("result", 128'(result), 128'(e_res[cyc]));
      if (e_row[cyc] != -1) begin
        em = '0; ek = '0;
        if (e_row[cyc] >= 0)
          for (int j = 0; j < K; j++) begin
            em[j*DW +: DW] = win[e_job[cyc]][e_row[cyc]*K + j];
            ek[j*DW +: DW] = ker[e_job[cyc]][e_row[cyc]*K + j];
          end
        chk("multiplier_out", 128'(multiplier_out), 128'(em));
        chk("multiplicand_out", 128'(multiplicand_out), 128'(ek));
      end
      if (cyc == j0 + 1) begin
        chk("lit_mstart", 128'(mStart), 128'(3'b111));
        chk("lit_row0", 128'(multiplier_out), 128'({32'd3, 32'd2, 32'd1}));
      end
      if (cyc == j0 + 8) chk("lit_rv_early", 128'(result_valid), 128'(1'b0));
      if (cyc == j0 + 9) begin
        chk("lit_rv", 128'(result_valid), 128'(1'b1));
        chk("lit_result", 128'(result), 128'(64'd45));
      end
    end
  end

  initial begin
    int c, fin, dn, en, hold_done;
    for (int k = 0; k < N; k++) begin
      e_row[k] = -1; e_job[k] = 0; s_start[k] = 0; s_facc[k] = '0; e_res[k] = '0;
    end
    for (int k = 1; k <= 3; k++) begin
      s_rst[k] = 1'b1; e_row[k] = -2; e_rchk[k] = 1'b1;
    end
    // job 0: window 1..9, kernel ones, single-cycle accelerator
    c = 6; j0 = c;
    for (int i = 0; i < K*K; i++) begin win[0][i] = DW'(i + 1); ker[0][i] = 32'd1; end
    set_dly(1, 1); dfin = 1;
    plan_job(0, c, 0, fin, dn, en);
    chk("model_sum", 128'(e_res[j0+9]), 128'(64'd45));
    chk("model_rv9", 128'(e_rv[j0+9]), 128'(1'b1));
    chk("model_rv8", 128'(e_rv[j0+8]), 128'(1'b0));
    // job 1: staggered lanes, result held 20 cycles with start high
    c = en + 1; rand_ops(1); set_dly(1, 4);
    dly[0][0] = 1; dly[0][1] = 5; dly[0][2] = 3; dfin = 2;
    plan_job(1, c, 20, fin, hold_done, en);
    for (int k = hold_done; k < en; k++) s_start[k] = 255;
    // job 2 accepted on the first idle cycle
    rand_ops(2); set_dly(1, 4); dfin = $urandom_range(3, 1);
    plan_job(2, en, $urandom_range(2, 0), fin, dn, en);
    // job 3: lane 2 never answers on row 1
    c = en + $urandom_range(2, 0); rand_ops(3); set_dly(1, 3); dly[1][2] = 0; dfin = 1;
    plan_job(3, c, 0, fin, dn, en);
    // job 4: slowest lane and final exactly at the limit
    c = en + 1; rand_ops(4); set_dly(1, 4); dly[0][1] = T; dfin = T;
    plan_job(4, c, 1, fin, dn, en);
    // job 5: final never returns
    c = en + 1; rand_ops(5); set_dly(1, 2); dfin = 0;
    plan_job(5, c, 0, fin, dn, en);
    // job 6: reset while waiting for the final sum
    c = en + 2; rand_ops(6); set_dly(1, 2); dfin = 6;
    plan_job(6, c, 0, fin, dn, en);
    apply_reset(fin + 2, 1, en);
    // jobs 7..11: random
    for (int j = 7; j < NJ; j++) begin
      c = en + $urandom_range(2, 0); rand_ops(j); set_dly(1, 5); dfin = $urandom_range(4, 1);
      plan_job(j, c, $urandom_range(3, 0), fin, dn, en);
    end
    n_run = en + 6;
    for (int k = 1; k < n_run; k++)
      if (e_busy[k] && s_start[k] == 0 && $urandom_range(3, 0) == 0) s_start[k] = 255;

    rst_n = 1'b0; start = 1'b0; window_in = '0; kernel_in = '0;
    mReady = '0; finalReady = 1'b0; finalAccumulate = '0; result_ready = 1'b0;
    for (int n = 1; n < n_run; n++) begin
      @(posedge clk);
      cyc = n;
      #1;
      rst_n = !s_rst[n];
      start = (s_start[n] != 0);
      if (s_start[n] >= 1 && s_start[n] <= NJ) begin
        for (int i = 0; i < K*K; i++) begin
          window_in[i*DW +: DW] = win[s_start[n]-1][i];
          kernel_in[i*DW +: DW] = ker[s_start[n]-1][i];
        end
      end else begin
        window_in = '1;
        for (int i = 0; i < K*K; i++) kernel_in[i*DW +: DW] = $urandom;
      end
      mReady = s_mready[n];
      finalReady = s_fready[n];
      finalAccumulate = s_fready[n] ? s_facc[n] : {$urandom, $urandom};
      result_ready = s_rready[n];
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
